// File: rtl/glb_capture_pkg.sv
// Shared definitions for the GLB stream capture sink.
// Contents: capture_state_t, the capture FSM state encoding.
package glb_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for the first flush after reset
    HDR  = 2'd1,  // expecting a block header (word count)
    DATA = 2'd2,  // consuming payload words of the current block
    DONE = 2'd3   // every block captured, stream stalled
  } capture_state_t;

endpackage

// File: rtl/glb_stream_capture_if.sv
// Ready/valid stream carrying GLB read words into the capture sink.
// Signals: data (header or payload word), valid (data valid), ready (sink ready).
// Handshake: a word transfers on a rising clock edge where valid && ready;
// the master holds data stable while valid is high and ready is low, and
// ready carries no dependency on valid.
interface glb_stream_capture_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/glb_capture_ram.sv
// Simple dual-port storage for all captured blocks.
// Ports: clk, rst_n (async, active-low, clears only the read register),
//   i_we/i_waddr/i_wdata (write port), i_re/i_raddr (read request),
//   o_rdata (registered read data, holds while i_re is low).
// Address is {block, word}; DEPTH is expected to be a power of two so that
// the concatenation maps densely onto NUM_BLOCKS*DEPTH words.
// A read and write to the same address in one cycle returns the old word.
module glb_capture_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int NUM_BLOCKS = 2,
  parameter int BLK_W      = 1,
  parameter int ADDR_W     = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [BLK_W+ADDR_W-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [BLK_W+ADDR_W-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int WORDS = NUM_BLOCKS * DEPTH;

  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage is deliberately not reset: contents survive flush and reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/glb_stream_capture.sv
// Capture sink for the GLB read stream. After each flush it accepts
// NUM_BLOCKS length-prefixed blocks (header = word count, then payload),
// stores each block in its own buffer region and exposes sizes and data
// through a read-back port.
// Ports: clk, rst_n (async, active-low); s_if (stream slave: data, valid,
//   ready); flush (restart capture); done (all blocks captured); error
//   (sticky, a header exceeded DEPTH); rd_en/rd_block/rd_addr -> rd_data
//   (1-cycle latency); rd_size (combinational header of rd_block);
//   dbg_state (current FSM state).
module glb_stream_capture
  import glb_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int NUM_BLOCKS = 2,
  localparam int BLK_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  glb_stream_capture_if.slave   s_if,
  input  logic                  flush,
  output logic                  done,
  output logic                  error,
  input  logic                  rd_en,
  input  logic [BLK_W-1:0]      rd_block,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] rd_size,
  output capture_state_t        dbg_state
);

  // One extra bit so a header of 2^DATA_WIDTH-1 never wraps the counter.
  localparam int                    CNT_W    = DATA_WIDTH + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [BLK_W-1:0]      LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

  capture_state_t        r_state;
  capture_state_t        w_next;
  logic [BLK_W-1:0]      r_blk;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_size [NUM_BLOCKS];
  logic                  r_ready;
  logic                  r_done;
  logic                  r_error;

  logic                  w_hs;
  logic                  w_last_blk;
  logic                  w_last_word;
  logic                  w_blk_adv;
  logic                  w_we;

  assign w_hs        = s_if.valid & r_ready;
  assign w_last_blk  = (r_blk == LAST_BLK);
  // Only evaluated in DATA, where the current size is at least 1.
  assign w_last_word = (r_cnt == ({1'b0, r_size[r_blk]} - CNT_W'(1)));

  always_comb begin
    w_next    = r_state;
    w_blk_adv = 1'b0;
    if (flush) begin
      w_next = HDR;
    end else begin
      case (r_state)
        IDLE: w_next = IDLE;
        HDR: begin
          if (w_hs) begin
            if (s_if.data == '0) begin
              // Empty block: finished at its own header.
              w_next    = w_last_blk ? DONE : HDR;
              w_blk_adv = ~w_last_blk;
            end else begin
              w_next = DATA;
            end
          end
        end
        DATA: begin
          if (w_hs && w_last_word) begin
            w_next    = w_last_blk ? DONE : HDR;
            w_blk_adv = ~w_last_blk;
          end
        end
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  // ready/done are derived from the next state so they are registered yet
  // keep ready high across block boundaries without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == HDR) || (w_next == DATA);
      r_done  <= (w_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk   <= '0;
      r_cnt   <= '0;
      r_error <= 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) r_size[i] <= '0;
    end else if (flush) begin
      // Flush drops any simultaneous handshake.
      r_blk   <= '0;
      r_cnt   <= '0;
      r_error <= 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) r_size[i] <= '0;
    end else begin
      if (w_blk_adv) r_blk <= r_blk + BLK_W'(1);
      if (r_state == HDR && w_hs) begin
        r_size[r_blk] <= s_if.data;
        r_cnt         <= '0;
        if ({1'b0, s_if.data} > DEPTH_C) r_error <= 1'b1;
      end else if (r_state == DATA && w_hs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Oversized blocks keep consuming words; only the first DEPTH are stored.
  assign w_we = (r_state == DATA) & w_hs & ~flush & (r_cnt < DEPTH_C);

  glb_capture_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .NUM_BLOCKS (NUM_BLOCKS),
    .BLK_W      (BLK_W),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr ({r_blk, r_cnt[ADDR_W-1:0]}),
    .i_wdata (s_if.data),
    .i_re    (rd_en),
    .i_raddr ({rd_block, rd_addr}),
    .o_rdata (rd_data)
  );

  assign s_if.ready = r_ready;
  assign done       = r_done;
  assign error      = r_error;
  assign rd_size    = (rd_block <= LAST_BLK) ? r_size[rd_block] : '0;
  assign dbg_state  = r_state;

endmodule
